// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: byte FIFO in front of an 8N1 serial transmitter (LSB first).
// The CPU stalls on txwait only when every FIFO slot is occupied.
//
//   state | meaning
//   IDLE  | line high, waiting for a byte in the FIFO
//   START | start bit (low) for one bit period
//   DATA  | eight data bits, LSB first, one bit period each
//   STOP  | stop bit (high) for one bit period
module uart_tx_fifo #(
  parameter int CLKDIV = 104,
  parameter int DEPTH  = 4,
  parameter int AW     = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       txstart,
  input  logic [7:0] txdata,
  output logic       txwait,
  output logic       tx,
  output logic       busy
);

  localparam int BW = $clog2(CLKDIV);
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLKDIV - 1);
  localparam logic [AW:0]   FULL      = (AW+1)'(DEPTH);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t        state, state_next;
  logic [BW-1:0] baud_cnt, baud_next;
  logic [2:0]    bit_cnt, bit_next;
  logic [7:0]    shreg, shreg_next;

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  logic          push, pop;

  // txwait depends only on the count register, so there is no path from txstart.
  assign txwait = (count == FULL);
  assign push   = txstart & ~txwait;
  assign pop    = (state == IDLE) && (count != '0);
  assign busy   = (count != '0) || (state != IDLE);

  // FIFO storage; no reset needed since the pointers qualify every read.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= txdata;
  end

  // FIFO pointers and occupancy; a simultaneous push and pop leaves count unchanged.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // Transmitter state, baud timer, bit counter and shift register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      baud_cnt <= '0;
      bit_cnt  <= '0;
      shreg    <= '0;
    end else begin
      state    <= state_next;
      baud_cnt <= baud_next;
      bit_cnt  <= bit_next;
      shreg    <= shreg_next;
    end
  end

  // Next-state logic: each bit period is CLKDIV cycles, ending when the baud timer hits zero.
  always_comb begin
    state_next = state;
    baud_next  = baud_cnt;
    bit_next   = bit_cnt;
    shreg_next = shreg;
    case (state)
      IDLE: begin
        if (pop) begin
          shreg_next = mem[rd_ptr];
          baud_next  = BAUD_LAST;
          state_next = START;
        end
      end
      START: begin
        if (baud_cnt == '0) begin
          baud_next  = BAUD_LAST;
          bit_next   = '0;
          state_next = DATA;
        end else begin
          baud_next = baud_cnt - BW'(1);
        end
      end
      DATA: begin
        if (baud_cnt == '0) begin
          baud_next  = BAUD_LAST;
          shreg_next = {1'b0, shreg[7:1]};
          if (bit_cnt == 3'd7) begin
            state_next = STOP;
          end else begin
            bit_next = bit_cnt + 3'd1;
          end
        end else begin
          baud_next = baud_cnt - BW'(1);
        end
      end
      STOP: begin
        if (baud_cnt == '0) begin
          state_next = IDLE;
        end else begin
          baud_next = baud_cnt - BW'(1);
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Registered line driver: follows the current state one clock later, glitch-free.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tx <= 1'b1;
    end else begin
      case (state)
        START:   tx <= 1'b0;
        DATA:    tx <= shreg[0];
        default: tx <= 1'b1;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo: random and directed byte streams against an 8N1 line decoder
// and an ordered queue of accepted bytes.
module tb_uart_tx_fifo;

  localparam int CLKDIV = 4;
  localparam int DEPTH  = 4;
  localparam int AW     = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       txstart = 1'b0;
  logic [7:0] txdata = 8'h00;
  logic       txwait, tx, busy;

  uart_tx_fifo #(.CLKDIV(CLKDIV), .DEPTH(DEPTH), .AW(AW)) dut (
    .clk(clk), .rst(rst), .txstart(txstart), .txdata(txdata),
    .txwait(txwait), .tx(tx), .busy(busy)
  );

  always #5 clk = ~clk;

  int         n_chk = 0;
  int         n_fail = 0;
  logic [7:0] exp_q[$];
  logic [7:0] rx_q[$];
  bit         mon_en = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Line decoder: samples each bit in the middle of its period.
  initial begin : rx_mon
    logic [7:0] b;
    bit ok;
    forever begin
      @(negedge clk);
      if (mon_en && rst && tx === 1'b0) begin
        ok = 1'b1;
        b = 8'h00;
        repeat (CLKDIV/2) @(negedge clk);
        if (tx !== 1'b0) ok = 1'b0;
        for (int i = 0; i < 8; i++) begin
          repeat (CLKDIV) @(negedge clk);
          b[i] = tx;
          if (!rst) ok = 1'b0;
        end
        repeat (CLKDIV) @(negedge clk);
        if (ok && rst) begin
          chk("stop_bit", {31'd0, tx}, 32'd1);
          rx_q.push_back(b);
        end
      end
    end
  end

  // CPU-side write: hold txstart until an edge where txwait was low. Entered and left at a negedge.
  task automatic push(input logic [7:0] d, output int stalls);
    bit w;
    bit done;
    stalls = 0;
    done = 1'b0;
    txstart = 1'b1;
    txdata = d;
    while (!done) begin
      w = txwait;
      @(posedge clk);
      @(negedge clk);
      if (!w) begin
        done = 1'b1;
        exp_q.push_back(d);
      end else begin
        stalls++;
        if (stalls > 2000) begin
          chk("push_timeout", 32'd1, 32'd0);
          done = 1'b1;
        end
      end
    end
  endtask

  task automatic wait_idle();
    int g;
    g = 0;
    while (busy && g < 5000) begin
      @(negedge clk);
      g++;
    end
    chk("idle_timeout", {31'd0, busy}, 32'd0);
    repeat (CLKDIV*3) @(negedge clk);
  endtask

  task automatic compare(input string tag);
    chk({tag, "_count"}, rx_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++)
      chk(tag, {24'd0, rx_q[i]}, {24'd0, exp_q[i]});
    rx_q.delete();
    exp_q.delete();
  endtask

  initial begin : main
    int         st;
    int         iaddr;
    logic [9:0] frame;
    logic [8:0] prog [4];

    #2 rst = 1'b0;
    #10;
    chk("reset_tx", {31'd0, tx}, 32'd1);
    chk("reset_txwait", {31'd0, txwait}, 32'd0);
    chk("reset_busy", {31'd0, busy}, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    mon_en = 1'b1;
    repeat (2) @(negedge clk);
    chk("idle_tx", {31'd0, tx}, 32'd1);

    // Single byte, bit-exact: accepted at edge E1, popped at E2, line low from E3.
    frame = {1'b1, 8'h41, 1'b0};
    push(8'h41, st);
    txstart = 1'b0;
    chk("busy_after_push", {31'd0, busy}, 32'd1);
    @(negedge clk);
    chk("latency_pre", {31'd0, tx}, 32'd1);
    @(negedge clk);
    for (int i = 0; i < 10*CLKDIV; i++) begin
      chk("frame_bit", {31'd0, tx}, {31'd0, frame[i/CLKDIV]});
      if (i == 10*CLKDIV-2) chk("busy_in_stop", {31'd0, busy}, 32'd1);
      if (i == 10*CLKDIV-1) chk("busy_after_stop", {31'd0, busy}, 32'd0);
      @(negedge clk);
    end
    chk("line_idle_after", {31'd0, tx}, 32'd1);
    wait_idle();
    compare("single");

    // Fill: first byte leaves at once, so the FIFO is full after the 5th accept.
    // The 6th waits for the first frame (10*CLKDIV cycles) plus the IDLE pop edge,
    // during which txwait is still high: 10*CLKDIV-2 stalled edges.
    for (int k = 0; k < 6; k++) begin
      push(8'h30 + 8'(k), st);
      chk("txwait_after_accept", {31'd0, txwait}, (k >= 4) ? 32'd1 : 32'd0);
      chk("stall_edges", st, (k == 5) ? 10*CLKDIV-2 : 0);
    end
    txstart = 1'b0;
    wait_idle();
    compare("fill");

    // Pointer wrap with random gaps.
    for (int k = 0; k < 3*DEPTH+1; k++) begin
      push(8'(k), st);
      txstart = 1'b0;
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    wait_idle();
    compare("wrap");

    // Random bytes, random gaps from back-to-back up to longer than a frame.
    for (int k = 0; k < 24; k++) begin
      push(8'($urandom), st);
      txstart = 1'b0;
      repeat ($urandom_range(0, 12*CLKDIV)) @(negedge clk);
    end
    wait_idle();
    compare("random");

    // CPU model running a program of two O instructions followed by a stop.
    prog[0] = 9'h148;
    prog[1] = 9'h149;
    prog[2] = 9'h000;
    prog[3] = 9'h000;
    iaddr = 0;
    while (iaddr < 4 && prog[iaddr][8]) begin
      push(prog[iaddr][7:0], st);
      txstart = 1'b0;
      iaddr++;
    end
    chk("cpu_iaddr", iaddr, 2);
    wait_idle();
    exp_q.delete();
    exp_q.push_back(8'h48);
    exp_q.push_back(8'h49);
    compare("cpu_hi");

    // Reset mid-frame with a full FIFO; line is in data bit 2 of 0xA0 (a zero).
    mon_en = 1'b0;
    for (int k = 0; k < 5; k++) push(8'hA0 + 8'(k), st);
    txstart = 1'b0;
    chk("full_before_reset", {31'd0, txwait}, 32'd1);
    repeat (10) @(negedge clk);
    chk("pre_reset_tx", {31'd0, tx}, 32'd0);
    #2 rst = 1'b0;
    #1;
    chk("async_reset_tx", {31'd0, tx}, 32'd1);
    chk("async_reset_txwait", {31'd0, txwait}, 32'd0);
    chk("async_reset_busy", {31'd0, busy}, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    exp_q.delete();
    rx_q.delete();
    repeat (3) @(negedge clk);
    chk("post_reset_tx", {31'd0, tx}, 32'd1);
    chk("post_reset_busy", {31'd0, busy}, 32'd0);
    mon_en = 1'b1;
    push(8'h5A, st);
    txstart = 1'b0;
    wait_idle();
    compare("post_reset");

    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end

endmodule
